// File: rtl/score_display.sv
// Score to saturated 4-digit BCD (double-dabble) with a multiplexed active-low 7-segment scan.
// Define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero one.
module score_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] score_in,
    output logic [15:0] bcd_out,
    output logic        overflow,
    output logic        busy,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t        state, state_nxt;
    logic [31:0]   shadow;
    logic [31:0]   bin;
    logic [39:0]   bcd;
    logic [4:0]    cnt;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [3:0]    nibble;
    logic          score_changed;

    function automatic logic [39:0] add3_all(input logic [39:0] v);
        logic [39:0] r;
        r = v;
        for (int i = 0; i < 10; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Clamp the 10-digit accumulator to four displayable digits; MSB is the overflow flag.
    function automatic logic [16:0] saturate(input logic [39:0] v);
        if (v[39:16] != 24'd0) return {1'b1, 16'h9999};
        return {1'b0, v[15:0]};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign score_changed = (score_in != shadow);
    assign busy          = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (score_changed) state_nxt = CONV;
            CONV:    if (cnt == 5'd31) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state    <= IDLE;
            shadow   <= 32'd0;
            bcd_out  <= 16'd0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && score_changed) shadow <= score_in;
            if (state == LOAD) {overflow, bcd_out} <= saturate(bcd);
        end
    end

    // Conversion datapath: only meaningful while CONV, so it carries no reset.
    always_ff @(posedge clock) begin
        case (state)
            IDLE: begin
                if (score_changed) begin
                    bin <= score_in;
                    bcd <= 40'd0;
                    cnt <= 5'd0;
                end
            end
            CONV: begin
                {bcd, bin} <= {add3_all(bcd), bin} << 1;
                cnt        <= cnt + 5'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign an_n   = ~(4'b0001 << idx);
    assign nibble = bcd_out[4*idx +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic blank_lead;

    // A 9999 overflow pattern is never zero above, so it is never blanked.
    always_comb begin
        blank_lead = 1'b0;
        case (idx)
            2'd1:    blank_lead = (bcd_out[15:4] == 12'd0);
            2'd2:    blank_lead = (bcd_out[15:8] == 8'd0);
            2'd3:    blank_lead = (bcd_out[15:12] == 4'd0);
            default: blank_lead = 1'b0;
        endcase
    end

    assign seg_n = blank_lead ? 7'h7F : seg_decode(nibble);
`else
    assign seg_n = seg_decode(nibble);
`endif

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: converted results queued at stimulus, checked at busy fall.
module tb_score_display;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic [31:0] score_in = 32'd0;
    logic [15:0] bcd_out;
    logic        overflow;
    logic        busy;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;

    int checks = 0;
    int errors = 0;
    logic [16:0] sb[$];

    score_display #(.SCAN_DIV(4)) dut (
        .clock(clock),
        .ctrl_reset(ctrl_reset),
        .score_in(score_in),
        .bcd_out(bcd_out),
        .overflow(overflow),
        .busy(busy),
        .seg_n(seg_n),
        .an_n(an_n)
    );

    always #5 clock = ~clock;

    function automatic logic [16:0] model(input logic [31:0] v);
        if (v > 32'd9999) return {1'b1, 16'h9999};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] tb_seg(input logic [3:0] d);
        logic [6:0] t[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d < 4'd10) ? t[d] : 7'h7F;
    endfunction

    task automatic drive_score(input logic [31:0] v, input bit push);
        @(negedge clock);
        score_in = v;
        if (push) sb.push_back(model(v));
    endtask

    task automatic wait_done(output int edges, output bit timeout);
        edges = 0;
        while (busy && edges < 200) begin
            @(posedge clock);
            #1;
            edges++;
        end
        timeout = busy;
    endtask

    task automatic pop_exp(output logic [16:0] e, output bit ok);
        ok = (sb.size() != 0);
        e  = ok ? sb.pop_front() : 17'h1FFFF;
    endtask

    task automatic sync_digit0(output bit found);
        logic [3:0] prev;
        found = 1'b0;
        prev  = an_n;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clock);
            #1;
            if (an_n == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = an_n;
        end
    endtask

    task automatic test_reset();
        int highs;
        #2 ctrl_reset = 1'b1;
        score_in = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        ctrl_reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({overflow, busy, bcd_out} !== 18'd0) begin
            errors++;
            $display("FAIL reset_regs ovf=%0b busy=%0b bcd=%h want 0 0 0000", overflow, busy, bcd_out);
        end
        checks++;
        if (an_n !== 4'b1110 || seg_n !== 7'h40) begin
            errors++;
            $display("FAIL reset_disp an_n=%b seg_n=%h want 1110 40", an_n, seg_n);
        end
        highs = 0;
        repeat (100) begin
            @(posedge clock);
            #1;
            if (busy !== 1'b0) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL reset_idle busy high %0d cycles want 0", highs);
        end
    endtask

    task automatic test_basic();
        int e; bit to, ok; logic [16:0] x;
        drive_score(32'd1234, 1'b1);
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b want 1", busy);
        end
        wait_done(e, to);
        checks++;
        if (to || e != 33) begin
            errors++;
            $display("FAIL basic_latency got %0d edges (timeout %0b) want 33", e, to);
        end
        pop_exp(x, ok);
        checks++;
        if (!ok || {overflow, bcd_out} !== x) begin
            errors++;
            $display("FAIL basic_value got %b/%h want %b/%h", overflow, bcd_out, x[16], x[15:0]);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] vals[3] = '{32'd10000, 32'hFFFF_FFFF, 32'd42};
        int e; bit to, ok; logic [16:0] x;
        for (int i = 0; i < 3; i++) begin
            drive_score(vals[i], 1'b1);
            @(posedge clock);
            #1;
            wait_done(e, to);
            pop_exp(x, ok);
            checks++;
            if (to || !ok || {overflow, bcd_out} !== x) begin
                errors++;
                $display("FAIL sat_%0d in=%h got %b/%h want %b/%h", i, vals[i], overflow, bcd_out, x[16], x[15:0]);
            end
        end
    endtask

    task automatic test_mid_change();
        int e; bit to, ok; logic [16:0] x;
        drive_score(32'd55, 1'b1);
        @(posedge clock);
        #1;
        repeat (10) @(posedge clock);
        drive_score(32'd77, 1'b1);
        wait_done(e, to);
        checks++;
        if (to || e != 23) begin
            errors++;
            $display("FAIL mid_first_latency got %0d edges want 23", e);
        end
        pop_exp(x, ok);
        checks++;
        if (!ok || {overflow, bcd_out} !== x) begin
            errors++;
            $display("FAIL mid_first_value got %h want %h", bcd_out, x[15:0]);
        end
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart busy got %b want 1", busy);
        end
        wait_done(e, to);
        checks++;
        if (to || e != 33) begin
            errors++;
            $display("FAIL mid_second_latency got %0d edges want 33", e);
        end
        pop_exp(x, ok);
        checks++;
        if (!ok || {overflow, bcd_out} !== x) begin
            errors++;
            $display("FAIL mid_second_value got %h want %h", bcd_out, x[15:0]);
        end
    endtask

    task automatic test_scan();
        int e; bit to, ok, found; logic [16:0] x; logic [15:0] pat;
        drive_score(32'd1234, 1'b1);
        @(posedge clock);
        #1;
        wait_done(e, to);
        pop_exp(x, ok);
        checks++;
        if (to || !ok || {overflow, bcd_out} !== x) begin
            errors++;
            $display("FAIL scan_value got %h want %h", bcd_out, x[15:0]);
        end
        pat = 16'h1234;
        sync_digit0(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL scan_sync an_n=%b never reached 1110", an_n);
        end
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (d != 0 || c != 0) begin
                    @(posedge clock);
                    #1;
                end
                checks++;
                if (an_n !== ~(4'b0001 << d) || seg_n !== tb_seg(pat[4*d +: 4])) begin
                    errors++;
                    $display("FAIL scan_d%0d_c%0d an_n=%b seg_n=%h want %b %h", d, c, an_n, seg_n,
                             ~(4'b0001 << d), tb_seg(pat[4*d +: 4]));
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        int e; bit to, ok, found; logic [16:0] x; logic [6:0] want;
        drive_score(32'd7, 1'b1);
        @(posedge clock);
        #1;
        wait_done(e, to);
        pop_exp(x, ok);
        checks++;
        if (to || !ok || {overflow, bcd_out} !== x) begin
            errors++;
            $display("FAIL lz_value got %h want %h", bcd_out, x[15:0]);
        end
        sync_digit0(found);
        for (int d = 0; d < 4; d++) begin
            if (d != 0) repeat (4) @(posedge clock);
            #1;
`ifdef LEADING_ZERO_BLANK_EN
            want = (d == 0) ? 7'h78 : 7'h7F;
`else
            want = (d == 0) ? 7'h78 : 7'h40;
`endif
            checks++;
            if (!found || an_n !== ~(4'b0001 << d) || seg_n !== want) begin
                errors++;
                $display("FAIL lz_d%0d an_n=%b seg_n=%h want %b %h", d, an_n, seg_n, ~(4'b0001 << d), want);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e; bit to, ok; logic [16:0] x;
        drive_score(32'd999, 1'b0);
        @(posedge clock);
        #1;
        repeat (9) @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        #1;
        checks++;
        if ({overflow, busy, bcd_out} !== 18'd0 || an_n !== 4'b1110 || seg_n !== 7'h40) begin
            errors++;
            $display("FAIL rstmid_regs ovf=%b busy=%b bcd=%h an=%b seg=%h want 0 0 0000 1110 40",
                     overflow, busy, bcd_out, an_n, seg_n);
        end
        @(negedge clock);
        ctrl_reset = 1'b0;
        sb.push_back(model(32'd999));
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart busy got %b want 1", busy);
        end
        wait_done(e, to);
        checks++;
        if (to || e != 33) begin
            errors++;
            $display("FAIL rstmid_latency got %0d edges want 33", e);
        end
        pop_exp(x, ok);
        checks++;
        if (!ok || {overflow, bcd_out} !== x) begin
            errors++;
            $display("FAIL rstmid_value got %h want %h", bcd_out, x[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_mid_change();
        test_scan();
        test_leading_zero();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain %0d results never produced", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
